// File: rtl/serial_loader.sv
// serial_loader: serializes one accepted byte LSB first into a downstream
// shift register, then drops we for a latch window of HOLD cycles.
//
// Parameters:
//   HOLD      - number of latch cycles after each frame, legal range 1..15
// Ports:
//   clk       - clock, all state changes on its rising edge
//   rst_n     - asynchronous active-low reset
//   data      - parallel byte to serialize
//   valid     - data is valid this cycle
//   ready     - block can accept a byte this cycle (registered)
//   ser_out   - serial bit to the downstream shift register input (registered)
//   we        - downstream shift enable, low requests its parallel latch (registered)
//   done      - one-cycle pulse at the start of a frame's latch window (registered)
//   frame_cnt - 16-bit wrapping count of done pulses, present only when
//               SERIAL_LOADER_FRAME_CNT_EN is defined
module serial_loader #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       ser_out,
  output logic       we,
  output logic       done
`ifdef SERIAL_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned BIT_W  = 3;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   shift_buf;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  // The last shift edge is the edge at which done is raised.
  logic last_bit_c;
  assign last_bit_c = (state == SHIFT) && (bit_cnt == BIT_W'(7));

  // Frame sequencer: accept, shift 8 bits LSB first, then hold the latch window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_buf <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      ready     <= 1'b1;
      ser_out   <= 1'b0;
      we        <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we      <= 1'b0;
          ser_out <= 1'b0;
          done    <= 1'b0;
          if (valid && ready) begin
            shift_buf <= data;
            bit_cnt   <= '0;
            state     <= SHIFT;
            ready     <= 1'b0;
            we        <= 1'b1;
            ser_out   <= data[0];
          end
        end
        SHIFT: begin
          if (last_bit_c) begin
            we       <= 1'b0;
            done     <= 1'b1;
            ser_out  <= 1'b0;
            hold_cnt <= HOLD_W'(1);
            state    <= LATCH;
          end else begin
            // bit 0 already went out on accept, so the next bit sits at [1]
            ser_out   <= shift_buf[1];
            shift_buf <= {1'b0, shift_buf[BYTE_W-1:1]};
            bit_cnt   <= bit_cnt + BIT_W'(1);
          end
        end
        LATCH: begin
          done <= 1'b0;
          we   <= 1'b0;
          if (hold_cnt == HOLD_W'(HOLD)) begin
            hold_cnt <= '0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          we      <= 1'b0;
          ser_out <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_LOADER_FRAME_CNT_EN
  // Counts edges where done is driven high; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (last_bit_c) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
